// File: rtl/clock_pkg.sv
// Shared types, constants and field-increment helpers for the clock front panel.
package clock_pkg;

  typedef logic [16:0] counter_t;
  typedef logic        flag_t;

  localparam counter_t COUNTER_MAX = 17'd86399;
  localparam counter_t MIN_TICK    = 17'd60;
  localparam counter_t HOUR_TICK   = 17'd3600;
  localparam counter_t HOUR_WRAP   = COUNTER_MAX + 17'd1 - HOUR_TICK;  // 82800
  localparam counter_t MIN_WRAP    = HOUR_TICK - MIN_TICK;             // 3540
  localparam counter_t SEC_WRAP    = MIN_TICK - 17'd1;                 // 59

  localparam logic [2:0] FIELD_NONE    = 3'd0;
  localparam logic [2:0] FIELD_SET_HR  = 3'd1;
  localparam logic [2:0] FIELD_SET_MIN = 3'd2;
  localparam logic [2:0] FIELD_SET_SEC = 3'd3;
  localparam logic [2:0] FIELD_ALM_HR  = 3'd4;
  localparam logic [2:0] FIELD_ALM_MIN = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_ALM_HR  = 3'd4,
    ST_ALM_MIN = 3'd5
  } state_t;

  function automatic counter_t inc_hour(input counter_t f);
    if (f >= HOUR_WRAP) inc_hour = f - HOUR_WRAP;
    else                inc_hour = f + HOUR_TICK;
  endfunction

  function automatic counter_t inc_min(input counter_t f);
    if ((f % HOUR_TICK) >= MIN_WRAP) inc_min = f - MIN_WRAP;
    else                             inc_min = f + MIN_TICK;
  endfunction

  function automatic counter_t inc_sec(input counter_t f);
    if ((f % MIN_TICK) == SEC_WRAP) inc_sec = f - SEC_WRAP;
    else                            inc_sec = f + 17'd1;
  endfunction

  function automatic logic [2:0] field_of(input state_t s);
    case (s)
      ST_SET_HR:  field_of = FIELD_SET_HR;
      ST_SET_MIN: field_of = FIELD_SET_MIN;
      ST_SET_SEC: field_of = FIELD_SET_SEC;
      ST_ALM_HR:  field_of = FIELD_ALM_HR;
      ST_ALM_MIN: field_of = FIELD_ALM_MIN;
      default:    field_of = FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-flop synchronizer, rising-edge detect and optional
// hold-to-repeat pulse generator. pulse = press | repeat tick.
module btn_cond #(
  parameter bit          REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD = 32'd5000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  input  logic clear,
  output logic pulse
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

  logic [1:0]       sync_r;
  logic             prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rep_r;
  logic             press_s;
  logic             fire_s;

  assign press_s = sync_r[1] & ~prev_r;
  assign pulse   = press_s | (REPEAT_EN & fire_s);

  // synchronizer and previous-value register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= 2'b00;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], btn};
      prev_r <= sync_r[1];
    end
  end

  // repeat tick: first after the hold delay, then once per period
  always_comb begin
    fire_s = 1'b0;
    if (sync_r[1] && !press_s) begin
      if (rep_r) fire_s = (cnt_r == PERIOD_C);
      else       fire_s = (cnt_r == DELAY_C);
    end else begin
      fire_s = 1'b0;
    end
  end

  // hold counter; the press cycle is count zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
      rep_r <= 1'b0;
    end else if (!sync_r[1] || clear || press_s) begin
      cnt_r <= {CNT_W{1'b0}};
      rep_r <= 1'b0;
    end else if (fire_s) begin
      cnt_r <= CNT_W'(1);
      rep_r <= 1'b1;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/input_ctrl.sv
// Front-panel edit sequencer for the time counter and alarm setpoint.
// Optional edit-state inactivity timeout: define INPUT_CTRL_TIMEOUT_EN.
module input_ctrl import clock_pkg::*; #(
  parameter int unsigned REPEAT_DELAY   = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD  = 32'd5000000
`ifdef INPUT_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 32'd500000000
`endif
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     btn_mode,
  input  logic     btn_alarm,
  input  logic     btn_inc,
  input  logic     alarm_en,
  input  counter_t counter_state,
  output logic     set_flag,
  output counter_t set_time,
  output logic     alarm_flag,
  output counter_t alarm_time,
  output logic [2:0] edit_field
);

  state_t   state_r;
  state_t   state_nxt;
  counter_t set_time_nxt;
  counter_t alarm_time_nxt;
  logic [1:0] en_sync_r;
  flag_t    mode_p;
  flag_t    alarm_p;
  flag_t    inc_p;
  flag_t    chg_s;
  flag_t    timeout_s;

  assign chg_s = (state_nxt != state_r);

  btn_cond #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_mode (
    .clock(clock), .reset_n(reset_n), .btn(btn_mode), .clear(chg_s), .pulse(mode_p)
  );

  btn_cond #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_alarm (
    .clock(clock), .reset_n(reset_n), .btn(btn_alarm), .clear(chg_s), .pulse(alarm_p)
  );

  btn_cond #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc (
    .clock(clock), .reset_n(reset_n), .btn(btn_inc), .clear(chg_s), .pulse(inc_p)
  );

`ifdef INPUT_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_r;
  flag_t           activity_s;

  assign activity_s = mode_p | alarm_p | inc_p;
  assign timeout_s  = (state_r != ST_IDLE) && !activity_s && (to_cnt_r == TO_LAST);

  // idle-cycle counter, reloaded by any press or state change
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if ((state_r == ST_IDLE) || activity_s || chg_s) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // next state and edited values; a mode press always beats an increment
  always_comb begin
    state_nxt      = state_r;
    set_time_nxt   = set_time;
    alarm_time_nxt = alarm_time;
    case (state_r)
      ST_IDLE: begin
        if (mode_p) begin
          state_nxt    = ST_SET_HR;
          set_time_nxt = counter_state;
        end else if (alarm_p) begin
          state_nxt      = ST_ALM_HR;
          alarm_time_nxt = alarm_time - (alarm_time % MIN_TICK);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SET_HR: begin
        if (mode_p)         state_nxt    = ST_SET_MIN;
        else if (inc_p)     set_time_nxt = inc_hour(set_time);
        else if (timeout_s) state_nxt    = ST_IDLE;
        else                state_nxt    = ST_SET_HR;
      end
      ST_SET_MIN: begin
        if (mode_p)         state_nxt    = ST_SET_SEC;
        else if (inc_p)     set_time_nxt = inc_min(set_time);
        else if (timeout_s) state_nxt    = ST_IDLE;
        else                state_nxt    = ST_SET_MIN;
      end
      ST_SET_SEC: begin
        if (mode_p)         state_nxt    = ST_IDLE;
        else if (inc_p)     set_time_nxt = inc_sec(set_time);
        else if (timeout_s) state_nxt    = ST_IDLE;
        else                state_nxt    = ST_SET_SEC;
      end
      ST_ALM_HR: begin
        if (mode_p)         state_nxt      = ST_ALM_MIN;
        else if (inc_p)     alarm_time_nxt = inc_hour(alarm_time);
        else if (timeout_s) state_nxt      = ST_IDLE;
        else                state_nxt      = ST_ALM_HR;
      end
      ST_ALM_MIN: begin
        if (mode_p)         state_nxt      = ST_IDLE;
        else if (inc_p)     alarm_time_nxt = inc_min(alarm_time);
        else if (timeout_s) state_nxt      = ST_IDLE;
        else                state_nxt      = ST_ALM_MIN;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // alarm enable synchronizer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_sync_r <= 2'b00;
    end else begin
      en_sync_r <= {en_sync_r[0], alarm_en};
    end
  end

  // state and registered outputs, all decoded from the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      set_flag   <= 1'b0;
      set_time   <= 17'd0;
      alarm_flag <= 1'b0;
      alarm_time <= 17'd0;
      edit_field <= FIELD_NONE;
    end else begin
      state_r    <= state_nxt;
      set_flag   <= (state_nxt == ST_SET_HR) || (state_nxt == ST_SET_MIN) || (state_nxt == ST_SET_SEC);
      set_time   <= set_time_nxt;
      alarm_flag <= en_sync_r[1] && (state_nxt != ST_ALM_HR) && (state_nxt != ST_ALM_MIN);
      alarm_time <= alarm_time_nxt;
      edit_field <= field_of(state_nxt);
    end
  end

endmodule

// File: tb/tb_input_ctrl.sv
// Scoreboard bench for input_ctrl with shortened repeat/timeout parameters.
module tb_input_ctrl;

  localparam logic [2:0] B_MODE  = 3'b100;
  localparam logic [2:0] B_ALARM = 3'b010;
  localparam logic [2:0] B_INC   = 3'b001;

  logic        clock;
  logic        reset_n;
  logic        btn_mode;
  logic        btn_alarm;
  logic        btn_inc;
  logic        alarm_en;
  logic [16:0] counter_state;
  logic        set_flag;
  logic [16:0] set_time;
  logic        alarm_flag;
  logic [16:0] alarm_time;
  logic [2:0]  edit_field;

  typedef struct {
    logic        sf;
    logic [16:0] st;
    logic        af;
    logic [16:0] at;
    logic [2:0]  ef;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // model of the front panel as seen from outside
  logic m_sf, m_en;
  int   m_st, m_at, m_ef;

  input_ctrl #(
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(4)
`ifdef INPUT_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .btn_mode(btn_mode), .btn_alarm(btn_alarm), .btn_inc(btn_inc),
    .alarm_en(alarm_en), .counter_state(counter_state),
    .set_flag(set_flag), .set_time(set_time),
    .alarm_flag(alarm_flag), .alarm_time(alarm_time),
    .edit_field(edit_field)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int add_hr(input int t);
    return (((t / 3600) + 1) % 24) * 3600 + (t % 3600);
  endfunction

  function automatic int add_min(input int t);
    return (t / 3600) * 3600 + ((((t / 60) % 60) + 1) % 60) * 60 + (t % 60);
  endfunction

  function automatic int add_sec(input int t);
    return (t / 60) * 60 + (((t % 60) + 1) % 60);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.sf = m_sf;
    e.st = 17'(m_st);
    e.af = m_en && (m_ef != 4) && (m_ef != 5);
    e.at = 17'(m_at);
    e.ef = 3'(m_ef);
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, ".set_flag"},   32'(set_flag),   32'(e.sf));
      check_val({tag, ".set_time"},   32'(set_time),   32'(e.st));
      check_val({tag, ".alarm_flag"}, 32'(alarm_flag), 32'(e.af));
      check_val({tag, ".alarm_time"}, 32'(alarm_time), 32'(e.at));
      check_val({tag, ".edit_field"}, 32'(edit_field), 32'(e.ef));
    end
  endtask

  task automatic expect_now(input string tag);
    push_exp();
    pop_cmp(tag);
  endtask

  // one-cycle press; returns just after the 3rd edge, where outputs reflect it
  task automatic press(input logic [2:0] mask);
    @(posedge clock); #1;
    {btn_mode, btn_alarm, btn_inc} = mask;
    @(posedge clock); #1;
    {btn_mode, btn_alarm, btn_inc} = 3'b000;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic hold_inc(input int n);
    @(posedge clock); #1;
    btn_inc = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    btn_inc = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  // mode press with model update for edit states
  task automatic mode_step(input string tag);
    press(B_MODE);
    case (m_ef)
      1: m_ef = 2;
      2: m_ef = 3;
      3: begin m_ef = 0; m_sf = 1'b0; end
      4: m_ef = 5;
      5: m_ef = 0;
      default: m_ef = 0;
    endcase
    expect_now(tag);
  endtask

  task automatic enter_time(input int cs, input string tag);
    counter_state = 17'(cs);
    press(B_MODE);
    m_sf = 1'b1; m_st = cs; m_ef = 1;
    expect_now(tag);
    counter_state = 17'd12345;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; btn_mode = 1'b0; btn_alarm = 1'b0; btn_inc = 1'b0;
    alarm_en = 1'b0; counter_state = 17'd0;
    m_sf = 1'b0; m_en = 1'b0; m_st = 0; m_at = 0; m_ef = 0;
    #22;
    expect_now("reset");
    @(negedge clock) reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // first entry with latency check: nothing visible after the 2nd edge
    counter_state = 17'd34953;
    @(posedge clock); #1 btn_mode = 1'b1;
    @(posedge clock); #1 btn_mode = 1'b0;
    @(posedge clock); #1 check_val("latency_edge2.edit_field", 32'(edit_field), 32'd0);
    @(posedge clock); #1;
    m_sf = 1'b1; m_st = 34953; m_ef = 1;
    expect_now("enter_hr");
    counter_state = 17'd0;
    press(B_INC);   m_st = add_hr(m_st);  expect_now("hr_inc");
    mode_step("to_min");
    press(B_INC);   m_st = add_min(m_st); expect_now("min_inc");
    mode_step("to_sec");
    mode_step("exit_set");
    press(B_INC);   expect_now("idle_inc_ignored");

    // wrap boundaries
    enter_time(86399, "enter_86399");
    press(B_INC);   m_st = add_hr(m_st);  expect_now("hr_wrap");
    press(B_ALARM); expect_now("alarm_ignored_in_set");
    mode_step("w1_min"); mode_step("w1_sec"); mode_step("w1_exit");
    enter_time(35999, "enter_35999a");
    mode_step("w2_min");
    press(B_INC);   m_st = add_min(m_st); expect_now("min_wrap");
    mode_step("w2_sec"); mode_step("w2_exit");
    enter_time(35999, "enter_35999b");
    mode_step("w3_min"); mode_step("w3_sec");
    press(B_INC);   m_st = add_sec(m_st); expect_now("sec_wrap");
    mode_step("w3_exit");

    // auto-repeat: 21-cycle hold gives press + 3 repeats
    enter_time(50924, "enter_50924");
    mode_step("r_min"); mode_step("r_sec");
    hold_inc(21);
    for (int i = 0; i < 4; i++) m_st = add_sec(m_st);
    expect_now("repeat_hold");
    mode_step("r_exit");

    // alarm edit
    alarm_en = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    m_en = 1'b1;
    expect_now("alarm_en_on");
    press(B_ALARM); m_ef = 4; m_at = m_at - (m_at % 60); expect_now("alm_enter");
    press(B_INC);   m_at = add_hr(m_at);  expect_now("alm_hr1");
    press(B_INC);   m_at = add_hr(m_at);  expect_now("alm_hr2");
    mode_step("alm_min");
    press(B_INC);   m_at = add_min(m_at); expect_now("alm_min_inc");
    mode_step("alm_exit");
    press(B_ALARM); m_ef = 4; m_at = m_at - (m_at % 60); expect_now("alm_reenter");
    mode_step("alm_min2"); mode_step("alm_exit2");

    // reset in the middle of a minute edit
    enter_time(38553, "pre_reset_enter");
    mode_step("pre_reset_min");
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    m_sf = 1'b0; m_st = 0; m_at = 0; m_ef = 0; m_en = 1'b0;
    expect_now("reset_mid_edit");
    @(negedge clock) reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    m_en = 1'b1;
    expect_now("post_reset");

    // simultaneous mode and inc: mode wins
    enter_time(34953, "sim_enter");
    press(B_MODE | B_INC); m_ef = 2; expect_now("mode_plus_inc");
    repeat (15) @(posedge clock);
    #1;
    expect_now("idle_15");
    repeat (10) @(posedge clock);
    #1;
`ifdef INPUT_CTRL_TIMEOUT_EN
    m_ef = 0; m_sf = 1'b0;
    expect_now("timeout_exit");
`else
    expect_now("no_timeout");
    mode_step("sim_sec");
    mode_step("sim_exit");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
